// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The sub signal exists only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high. Valid never depends on ready.
  modport master (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit chunk per clock, LSB chunk first.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_adder_if.slave    bus,
  output logic [1:0]              debug_state
);
  localparam int NCHUNK = WIDTH / 4;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] partial;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_out_reg;
  logic             overflow_reg;

  logic [3:0]       a_chunk;
  logic [3:0]       b_chunk;
  logic [3:0]       chunk_sum;
  logic             chunk_carry;
  logic [3:0]       low3;
  logic             msb_carry_in;
  logic [WIDTH-1:0] partial_next;
  logic             last_chunk;
  logic             sub_sel;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  // One 4-bit ripple slice; low3 recovers the carry into the slice's top bit
  // so overflow can be formed on the final chunk.
  always_comb begin
    a_chunk                        = a_reg[{idx, 2'b00} +: 4];
    b_chunk                        = b_reg[{idx, 2'b00} +: 4];
    {chunk_carry, chunk_sum}       = {1'b0, a_chunk} + {1'b0, b_chunk} + {4'b0000, carry_reg};
    low3                           = {1'b0, a_chunk[2:0]} + {1'b0, b_chunk[2:0]} + {3'b000, carry_reg};
    msb_carry_in                   = low3[3];
    partial_next                   = partial;
    partial_next[{idx, 2'b00} +: 4] = chunk_sum;
    last_chunk                     = (idx == IW'(NCHUNK - 1));
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = ADD;
      end
      ADD: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      partial       <= '0;
      carry_reg     <= 1'b0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1, so invert b once at capture.
            a_reg     <= bus.a;
            b_reg     <= sub_sel ? ~bus.b : bus.b;
            carry_reg <= sub_sel ? 1'b1 : bus.carry_in;
            idx       <= '0;
            partial   <= '0;
          end
        end
        ADD: begin
          partial   <= partial_next;
          carry_reg <= chunk_carry;
          if (last_chunk) begin
            idx           <= '0;
            sum_reg       <= partial_next;
            carry_out_reg <= chunk_carry;
            overflow_reg  <= msb_carry_in ^ chunk_carry;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum       = sum_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.overflow  = overflow_reg;
  assign debug_state   = state;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with a result scoreboard.
// Subtract cases run when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] debug_state;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .debug_state (debug_state)
  );

  logic [W+1:0] exp_q[$];  // {sum, carry_out, overflow}
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic cin, input logic s);
    logic [W-1:0] yy;
    logic         c0;
    logic [W:0]   t;
    logic         ovf;
    yy  = s ? ~y : y;
    c0  = s ? 1'b1 : cin;
    t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
    ovf = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {t[W-1:0], t[W], ovf};
  endfunction

  // Presents one operation and returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic cin, input logic s);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.a        = x;
    bus.b        = y;
    bus.carry_in = cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    bus.sub      = s;
`endif
    @(posedge clk);
    exp_q.push_back(model(x, y, cin, s));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // Waits for out_valid, scores the result, optionally backpressures, then
  // completes the output handshake and checks the return to IDLE.
  task automatic finish_op(input string tag, input int hold);
    int           lat;
    logic [W+1:0] e;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    if (!bus.out_valid) return;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_result"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_sum"},       32'(bus.sum),       32'(e[W+1:2]));
    check({tag, "_carry_out"}, 32'(bus.carry_out), 32'(e[1]));
    check({tag, "_overflow"},  32'(bus.overflow),  32'(e[0]));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'h0F0F;
      bus.b        = 16'h0101;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_sum"},   32'(bus.sum),       32'(e[W+1:2]));
      check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_sum"},   32'(bus.sum),       32'(e[W+1:2]));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif

    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_carry_out", 32'(bus.carry_out), 32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_state",     32'(debug_state),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(16'h0002, 16'h0003, 1'b0, 1'b0);
    finish_op("add_small", 0);

    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    finish_op("ripple_all", 0);

    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    finish_op("pos_ovf", 0);

    start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    finish_op("neg_ovf", 0);

    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    finish_op("cin_ones", 0);

    bus.out_ready = 1'b0;
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    finish_op("backpressure", 3);

    // Abort after two chunks; no result may appear.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("mid_add_state", 32'(debug_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_sum",       32'(bus.sum),       32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_state",     32'(debug_state),   32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    start_op(16'h000A, 16'h0005, 1'b0, 1'b0);
    finish_op("after_abort", 0);

    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      rc = 1'($urandom_range(0, 1));
      start_op(ra, rb, rc, 1'b0);
      finish_op("random", 0);
    end

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    finish_op("sub_borrow", 0);
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    finish_op("sub_ovf", 0);
    start_op(16'h0009, 16'h0004, 1'b1, 1'b0);
    finish_op("sub_off_add", 0);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
